mvu_pe_acc: RTL and testbench
=============================

MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter PE, default 2: number of PE lanes consumed in parallel.
REQ-003 Parameter TO, default 2: signed width of each PE output lane.
REQ-004 Parameter TA, default 16: signed accumulator and output lane width; TA >= TO SHALL hold.
REQ-005 Parameter SF, default 4: synapse fold, the number of PE results summed per output; SF >= 1.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_pe  in  PE x TO  packed signed PE results; lane i is in_pe[i].
REQ-009 in_v  in  1  in_pe valid.
REQ-010 in_rdy  out  1  block can accept in_pe this cycle.
REQ-011 out_acc  out  PE x TA  packed signed accumulated results.
REQ-012 out_v  out  1  out_acc valid.
REQ-013 out_rdy  in  1  downstream accepts out_acc.

Function
REQ-014 Input accept SHALL occur on a rising clk edge with in_v=1 and in_rdy=1; output accept SHALL occur with out_v=1 and out_rdy=1.
REQ-015 A fold counter SHALL count accepted inputs from 0 to SF-1 and wrap to 0 after the accept at SF-1.
REQ-016 On an accept with counter=0, each lane accumulator SHALL load sign-extended in_pe[i]; otherwise it SHALL add sign-extended in_pe[i].
REQ-017 Accumulation SHALL be two's-complement modulo 2^TA, with no saturation or overflow flag.
REQ-018 On the accept at counter=SF-1, the final sum (accumulator plus current input) SHALL load into the out_acc register and set out_v=1 on that same edge, so out_v rises one cycle after the final accept.
REQ-019 The output register SHALL have two states, EMPTY (out_v=0) and FULL (out_v=1).
  - EMPTY to FULL: on the final-fold accept.
  - FULL to EMPTY: on an output accept with no simultaneous final-fold accept.
  - FULL to FULL with new data: on a simultaneous output accept and final-fold accept.
REQ-020 While FULL, out_acc SHALL remain stable until accepted.
REQ-021 in_rdy SHALL be 0 only when counter=SF-1, out_v=1 and out_rdy=0, and SHALL be 1 otherwise.
  - Non-final folds continue to accumulate while the output is stalled.
  - in_rdy depends combinationally on out_rdy; there is no combinational path from in_v to in_rdy.
REQ-022 Gaps in in_v SHALL NOT alter the counter or the accumulators.
REQ-023 With SF=1, every accepted input SHALL appear sign-extended on out_acc one cycle later.
REQ-024 Sustained throughput SHALL be one input per cycle when out_rdy=1.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear out_v, out_acc, all accumulators and the fold counter to 0.
REQ-026 A partial fold in progress at reset SHALL be discarded, and a held output SHALL be dropped.
REQ-027 in_rdy SHALL read 1 while rst_n=0 and after reset release.

Verification
REQ-028 Basic sum (PE=2, TO=8, TA=16, SF=4, out_rdy=1): lane0 inputs 1,2,3,4 and lane1 inputs -1,-2,-3,-4 on consecutive cycles -> out_v=1 for exactly one cycle, one cycle after the 4th accept, with out_acc={-10,10}.
REQ-029 Backpressure: hold out_rdy=0 after the first result and stream a second group of all-1 inputs.
  - Folds 1-3 are accepted.
  - in_rdy=0 while the 4th input is presented, and out_acc stays {-10,10}.
  - Raising out_rdy accepts the held result and the stalled input in the same cycle.
  - The next cycle shows out_acc={4,4}.
REQ-030 Wrap (TO=8, TA=8, SF=4): four inputs of 100 on lane0 -> out_acc lane0 = 8'h90 (-112).
REQ-031 Reset mid-fold: pulse rst_n low after 2 accepts -> out_v=0 immediately; the next four inputs of 1 yield out_acc={4,4}.
REQ-032 Gapped input: the same stimulus as REQ-028 with in_v=0 on alternate cycles -> identical result {-10,10}.
REQ-033 SF=1: input 8'hFF on lane0 -> next cycle out_acc lane0 = 16'hFFFF and out_v=1.

Source files
------------

// File: rtl/mvu_pe_acc.sv
// Per-lane accumulator for a matrix-vector PE array.
// It sums SF consecutive accepted PE results into a one-entry output register with valid/ready handshakes.
module mvu_pe_acc #(
   parameter int PE = 2,
   parameter int TO = 2,
   parameter int TA = 16,
   parameter int SF = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [PE-1:0][TO-1:0]  in_pe,
   input  logic                   in_v,
   output logic                   in_rdy,
   output logic [PE-1:0][TA-1:0]  out_acc,
   output logic                   out_v,
   input  logic                   out_rdy
);

   localparam int CW = (SF > 1) ? $clog2(SF) : 1;
   localparam logic [CW-1:0] LAST = CW'(SF - 1);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [PE-1:0][TA-1:0]  acc;
   logic [PE-1:0][TA-1:0]  ext;
   logic [PE-1:0][TA-1:0]  sum;
   logic                   in_fire;
   logic                   out_fire;
   logic                   last_fire;

   // Only the final fold needs room in the output register; earlier folds keep flowing during a stall.
   assign out_v     = (state == FULL);
   assign in_rdy    = !((cnt == LAST) && out_v && !out_rdy);
   assign in_fire   = in_v && in_rdy;
   assign out_fire  = out_v && out_rdy;
   assign last_fire = in_fire && (cnt == LAST);

   always_comb begin
      ext = '0;
      sum = '0;
      for (int i = 0; i < PE; i++) begin
         ext[i] = TA'($signed(in_pe[i]));
         sum[i] = (cnt == '0) ? ext[i] : acc[i] + ext[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (in_fire) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
         acc <= sum;
      end
   end

   // A simultaneous drain and final fold refills the register, so it stays FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         out_acc <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (last_fire) begin
                  state   <= FULL;
                  out_acc <= sum;
               end
            end
            FULL: begin
               if (last_fire) begin
                  out_acc <= sum;
               end else if (out_fire) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Self-checking bench for mvu_pe_acc.
// Covers directed vectors, backpressure, reset and gaps, random traffic against a fold-sum model, wrap and SF=1.
module tb_mvu_pe_acc;

   logic              clk;
   logic              rst_n;
   logic [1:0][7:0]   in_pe;
   logic              in_v;
   logic              in_rdy;
   logic [1:0][15:0]  out_acc;
   logic              out_v;
   logic              out_rdy;

   logic [1:0][7:0]   w_in_pe;
   logic              w_in_v;
   logic              w_in_rdy;
   logic [1:0][7:0]   w_out_acc;
   logic              w_out_v;
   logic              w_out_rdy;

   logic [1:0][7:0]   s_in_pe;
   logic              s_in_v;
   logic              s_in_rdy;
   logic [1:0][15:0]  s_out_acc;
   logic              s_out_v;
   logic              s_out_rdy;

   int total = 0;
   int bad   = 0;

   mvu_pe_acc #(.PE(2), .TO(8), .TA(16), .SF(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_pe(in_pe), .in_v(in_v), .in_rdy(in_rdy),
      .out_acc(out_acc), .out_v(out_v), .out_rdy(out_rdy));

   mvu_pe_acc #(.PE(2), .TO(8), .TA(8), .SF(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_pe(w_in_pe), .in_v(w_in_v), .in_rdy(w_in_rdy),
      .out_acc(w_out_acc), .out_v(w_out_v), .out_rdy(w_out_rdy));

   mvu_pe_acc #(.PE(2), .TO(8), .TA(16), .SF(1)) dut_1 (
      .clk(clk), .rst_n(rst_n), .in_pe(s_in_pe), .in_v(s_in_v), .in_rdy(s_in_rdy),
      .out_acc(s_out_acc), .out_v(s_out_v), .out_rdy(s_out_rdy));

   typedef struct {
      int a0 [4];
      int a1 [4];
      int e0;
      int e1;
   } vec_t;

   vec_t tbl [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input int l0, input int l1, input logic rdy);
      in_v    = v;
      in_pe   = {8'(l1), 8'(l0)};
      out_rdy = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pack2(input int l0, input int l1);
      return {16'(l1), 16'(l0)};
   endfunction

   int          pend0 [$];
   int          pend1 [$];
   logic [31:0] resq  [$];

   initial begin
      tbl[0].a0 = '{1, 2, 3, 4};          tbl[0].a1 = '{-1, -2, -3, -4};
      tbl[0].e0 = 10;                     tbl[0].e1 = -10;
      tbl[1].a0 = '{5, -5, 7, -128};      tbl[1].a1 = '{127, 127, 127, 127};
      tbl[1].e0 = -121;                   tbl[1].e1 = 508;
      tbl[2].a0 = '{0, 0, 0, 0};          tbl[2].a1 = '{100, -50, 25, -1};
      tbl[2].e0 = 0;                      tbl[2].e1 = 74;
      tbl[3].a0 = '{-128, -128, -128, -128}; tbl[3].a1 = '{-1, 1, -1, 1};
      tbl[3].e0 = -512;                   tbl[3].e1 = 0;

      rst_n = 1'b0;
      in_v = 1'b0; in_pe = '0; out_rdy = 1'b1;
      w_in_v = 1'b0; w_in_pe = '0; w_out_rdy = 1'b1;
      s_in_v = 1'b0; s_in_pe = '0; s_out_rdy = 1'b1;
      #2;
      checkOutput("reset_in_rdy", 64'(in_rdy), 64'd1);
      checkOutput("reset_out_v", 64'(out_v), 64'd0);
      checkOutput("reset_out_acc", 64'(out_acc), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 checkOutput("post_reset_in_rdy", 64'(in_rdy), 64'd1);

      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, tbl[t].a0[k], tbl[t].a1[k], 1'b1);
            if (k == 3) checkOutput("tbl_pre_out_v", 64'(out_v), 64'd0);
            tick();
         end
         applyStimulus(1'b0, 0, 0, 1'b1);
         checkOutput("tbl_out_v", 64'(out_v), 64'd1);
         checkOutput("tbl_out_acc", 64'(out_acc), 64'(pack2(tbl[t].e0, tbl[t].e1)));
         tick();
         checkOutput("tbl_out_v_drop", 64'(out_v), 64'd0);
      end

      // Backpressure: result held while the next group streams in.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, tbl[0].a0[k], tbl[0].a1[k], 1'b0);
         tick();
      end
      checkOutput("bp_held_v", 64'(out_v), 64'd1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1, 1, 1'b0);
         checkOutput("bp_fold_rdy", 64'(in_rdy), 64'd1);
         tick();
         checkOutput("bp_fold_acc", 64'(out_acc), 64'(pack2(10, -10)));
      end
      applyStimulus(1'b1, 1, 1, 1'b0);
      checkOutput("bp_stall_rdy", 64'(in_rdy), 64'd0);
      tick();
      checkOutput("bp_stall_acc", 64'(out_acc), 64'(pack2(10, -10)));
      checkOutput("bp_stall_rdy2", 64'(in_rdy), 64'd0);
      applyStimulus(1'b1, 1, 1, 1'b1);
      checkOutput("bp_release_rdy", 64'(in_rdy), 64'd1);
      tick();
      checkOutput("bp_new_v", 64'(out_v), 64'd1);
      checkOutput("bp_new_acc", 64'(out_acc), 64'(pack2(4, 4)));
      applyStimulus(1'b0, 0, 0, 1'b1);
      tick();
      checkOutput("bp_drain_v", 64'(out_v), 64'd0);

      // Reset mid-fold with a held output present.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 2, 2, 1'b0);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 7, 7, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 0, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_out_v", 64'(out_v), 64'd0);
      checkOutput("rst_mid_out_acc", 64'(out_acc), 64'd0);
      checkOutput("rst_mid_in_rdy", 64'(in_rdy), 64'd1);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1, 1, 1'b1);
         tick();
      end
      checkOutput("rst_after_v", 64'(out_v), 64'd1);
      checkOutput("rst_after_acc", 64'(out_acc), 64'(pack2(4, 4)));

      // Gapped input with junk data on idle cycles.
      for (int k = 0; k < 7; k++) begin
         if (k % 2 == 0) applyStimulus(1'b1, tbl[0].a0[k/2], tbl[0].a1[k/2], 1'b1);
         else            applyStimulus(1'b0, 99, -77, 1'b1);
         tick();
      end
      checkOutput("gap_out_v", 64'(out_v), 64'd1);
      checkOutput("gap_out_acc", 64'(out_acc), 64'(pack2(10, -10)));
      applyStimulus(1'b0, 0, 0, 1'b1);
      tick();

      // Random traffic against a model that sums each group of four accepted inputs.
      doReset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic v, rdy, exp_rdy, in_fire, out_fire;
         int   l0, l1, s0, s1;
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         l0  = int'($urandom_range(0, 255)) - 128;
         l1  = int'($urandom_range(0, 255)) - 128;
         applyStimulus(v, l0, l1, rdy);
         exp_rdy = !(pend0.size() == 3 && resq.size() > 0 && !rdy);
         checkOutput("rnd_in_rdy", 64'(in_rdy), 64'(exp_rdy));
         in_fire  = v && exp_rdy;
         out_fire = (resq.size() > 0) && rdy;
         tick();
         if (out_fire) void'(resq.pop_front());
         if (in_fire) begin
            pend0.push_back(l0);
            pend1.push_back(l1);
            if (pend0.size() == 4) begin
               s0 = pend0.sum();
               s1 = pend1.sum();
               resq.push_back(pack2(s0, s1));
               pend0.delete();
               pend1.delete();
            end
         end
         checkOutput("rnd_out_v", 64'(out_v), 64'(resq.size() > 0));
         if (resq.size() > 0) checkOutput("rnd_out_acc", 64'(out_acc), 64'(resq[0]));
      end
      applyStimulus(1'b0, 0, 0, 1'b1);

      // Modulo wrap with TA == TO.
      w_in_v  = 1'b1;
      w_in_pe = {8'(-100), 8'd100};
      repeat (4) tick();
      w_in_v = 1'b0;
      checkOutput("wrap_out_v", 64'(w_out_v), 64'd1);
      checkOutput("wrap_out_acc", 64'(w_out_acc), 64'h7090);

      // SF=1 passes each input straight through, sign-extended.
      s_in_v  = 1'b1;
      s_in_pe = {8'h05, 8'hFF};
      #1 checkOutput("sf1_pre_v", 64'(s_out_v), 64'd0);
      tick();
      checkOutput("sf1_v", 64'(s_out_v), 64'd1);
      checkOutput("sf1_acc", 64'(s_out_acc), 64'h0005FFFF);
      s_in_pe = {8'h80, 8'h7F};
      tick();
      checkOutput("sf1_acc2", 64'(s_out_acc), 64'hFF80007F);
      s_in_v = 1'b0;
      tick();
      checkOutput("sf1_drain_v", 64'(s_out_v), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
